// File: rtl/spi_minion_packet_frontend.sv
// spi_minion_packet_frontend
//   SPI minion (mode 0) front end that feeds a val/rdy packet interconnect.
//   Each frame is sampled into the clk domain, deserialised MSB first into a
//   BIT_WIDTH packet and offered on rx_msg/rx_val. In the same frame, one
//   response packet is serialised onto miso. clk must run at least 8x sclk.
// Ports
//   clk, reset        system clock, async active-high reset
//   cs, sclk, mosi    raw SPI pins (asynchronous to clk)
//   miso              SPI data out (0 outside an active frame)
//   rx_msg/val/rdy    received packet, val/rdy handshake
//   tx_msg/val/rdy    response packet; tx_rdy is a 1-cycle take pulse
//   minion_parity     ^rx_msg while rx_val, else 0
//   frame_err         1-cycle pulse when a frame length is not BIT_WIDTH
//   overflow          sticky: a good frame was dropped because rx was full
module spi_minion_packet_frontend #(
    parameter int BIT_WIDTH   = 20,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cs,
    input  logic                 sclk,
    input  logic                 mosi,
    output logic                 miso,
    output logic [BIT_WIDTH-1:0] rx_msg,
    output logic                 rx_val,
    input  logic                 rx_rdy,
    input  logic [BIT_WIDTH-1:0] tx_msg,
    input  logic                 tx_val,
    output logic                 tx_rdy,
    output logic                 minion_parity,
    output logic                 frame_err,
    output logic                 overflow
);

    localparam int CW = $clog2(BIT_WIDTH + 2);
    localparam logic [CW-1:0] CNT_FULL = CW'(BIT_WIDTH);
    localparam logic [CW-1:0] CNT_MAX  = CW'(BIT_WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] cs_sync, sclk_sync, mosi_sync;
    logic                   cs_d, sclk_d;
    logic                   cs_s, sclk_s, mosi_s;
    logic                   sclk_rise, sclk_fall, cs_fall, cs_rise;

    logic [BIT_WIDTH-1:0]   rx_shift, tx_shift;
    logic [CW-1:0]          count;

    // Synchronisers preset to the idle bus (cs high, sclk low) so that
    // leaving reset never fabricates an edge on an idle bus.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cs_sync   <= '1;
            sclk_sync <= '0;
            mosi_sync <= '0;
            cs_d      <= 1'b1;
            sclk_d    <= 1'b0;
        end else begin
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            cs_d      <= cs_s;
            sclk_d    <= sclk_s;
        end
    end

    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    // mosi goes through the same depth as sclk, so it lines up with sclk_rise.
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign cs_fall   = ~cs_s & cs_d;
    assign cs_rise   = cs_s & ~cs_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cs_fall) state_d = SHIFT;
            SHIFT:   if (cs_rise) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The response is taken at frame start even if the frame later turns
    // out to be malformed.
    assign tx_rdy = (state_q == IDLE) && cs_fall && tx_val;
    assign miso   = (state_q == SHIFT) ? tx_shift[BIT_WIDTH-1] : 1'b0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_shift      <= '0;
            tx_shift      <= '0;
            count         <= '0;
            rx_msg        <= '0;
            rx_val        <= 1'b0;
            minion_parity <= 1'b0;
            frame_err     <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            frame_err <= 1'b0;

            // Handshake first; a DONE load below overrides the clear.
            if (rx_val && rx_rdy) begin
                rx_val        <= 1'b0;
                minion_parity <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (cs_fall) begin
                        tx_shift <= tx_val ? tx_msg : '0;
                        rx_shift <= '0;
                        count    <= '0;
                    end
                end
                SHIFT: begin
                    if (sclk_rise) begin
                        rx_shift <= {rx_shift[BIT_WIDTH-2:0], mosi_s};
                        if (count != CNT_MAX) count <= count + 1'b1;
                    end
                    if (sclk_fall)
                        tx_shift <= {tx_shift[BIT_WIDTH-2:0], 1'b0};
                end
                DONE: begin
                    if (count != CNT_FULL) begin
                        frame_err <= 1'b1;
                    end else if (!rx_val || rx_rdy) begin
                        rx_msg        <= rx_shift;
                        rx_val        <= 1'b1;
                        minion_parity <= ^rx_shift;
                    end else begin
                        overflow <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_minion_packet_frontend.sv
// Directed bench for spi_minion_packet_frontend (BIT_WIDTH=20, SYNC_STAGES=2).
// clk period 10, sclk period 100; all stimulus changes land on multiples of
// 10 so they never coincide with a rising clk edge.
module tb_spi_minion_packet_frontend;

    localparam int BW = 20;

    logic          clk = 1'b0;
    logic          reset;
    logic          cs, sclk, mosi, miso;
    logic [BW-1:0] rx_msg, tx_msg;
    logic          rx_val, rx_rdy, tx_val, tx_rdy;
    logic          minion_parity, frame_err, overflow;

    int checks   = 0;
    int failures = 0;

    // Monitor counters (cleared by mon_clr)
    logic          mon_clr;
    int            xfer_cnt, err_cnt, rdy_cnt, val_cycles, val_falls;
    logic [BW-1:0] last_xfer;
    logic          last_par, prev_val;
    logic [31:0]   miso_bits;

    spi_minion_packet_frontend #(.BIT_WIDTH(BW), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .cs(cs), .sclk(sclk), .mosi(mosi), .miso(miso),
        .rx_msg(rx_msg), .rx_val(rx_val), .rx_rdy(rx_rdy),
        .tx_msg(tx_msg), .tx_val(tx_val), .tx_rdy(tx_rdy),
        .minion_parity(minion_parity), .frame_err(frame_err), .overflow(overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mon_clr) begin
            xfer_cnt   <= 0;
            err_cnt    <= 0;
            rdy_cnt    <= 0;
            val_cycles <= 0;
            val_falls  <= 0;
            last_xfer  <= '0;
            last_par   <= 1'b0;
            prev_val   <= 1'b0;
        end else begin
            if (rx_val && rx_rdy) begin
                xfer_cnt  <= xfer_cnt + 1;
                last_xfer <= rx_msg;
                last_par  <= minion_parity;
            end
            if (frame_err) err_cnt <= err_cnt + 1;
            if (tx_rdy) rdy_cnt <= rdy_cnt + 1;
            if (rx_val) val_cycles <= val_cycles + 1;
            if (prev_val && !rx_val) val_falls <= val_falls + 1;
            prev_val <= rx_val;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; cs = 1'b1; sclk = 1'b0; mosi = 1'b0;
        mon_clr = 1'b1;
        #20 reset = 1'b0;
        #20 mon_clr = 1'b0;
        #20;
    endtask

    // One sclk period: set mosi, sample miso just before the rising edge.
    task automatic sbit(input logic b);
        mosi = b;
        #50 miso_bits = {miso_bits[30:0], miso};
        sclk = 1'b1;
        #50 sclk = 1'b0;
    endtask

    // Full frame of n bits. With rdy_window, rx_rdy is high only for the
    // DONE cycle (raw cs rise + 30..40 for two sync stages).
    task automatic frame(input logic [31:0] d, input int n, input bit rdy_window);
        miso_bits = '0;
        cs = 1'b0;
        #100 tx_val = 1'b0;
        for (int i = 0; i < n; i++) sbit(d[n-1-i]);
        #50 cs = 1'b1;
        if (rdy_window) begin
            #30 rx_rdy = 1'b1;
            #10 rx_rdy = 1'b0;
            #60;
        end else begin
            #100;
        end
        #100;
    endtask

    initial begin
        reset = 1'b1; cs = 1'b1; sclk = 1'b0; mosi = 1'b0;
        rx_rdy = 1'b0; tx_val = 1'b0; tx_msg = '0; mon_clr = 1'b1;
        miso_bits = '0;

        // Reset state
        #20;
        chk("rst_miso", 32'(miso), 0);
        chk("rst_rx_val", 32'(rx_val), 0);
        chk("rst_rx_msg", 32'(rx_msg), 0);
        chk("rst_tx_rdy", 32'(tx_rdy), 0);
        chk("rst_parity", 32'(minion_parity), 0);
        chk("rst_frame_err", 32'(frame_err), 0);
        chk("rst_overflow", 32'(overflow), 0);
        #20 reset = 1'b0;
        #20 mon_clr = 1'b0;
        #20;

        // 1: reset after 7 bits, then a clean frame
        rx_rdy = 1'b1;
        cs = 1'b0;
        #100;
        for (int i = 0; i < 7; i++) sbit(1'b1);
        reset = 1'b1; cs = 1'b1; sclk = 1'b0;
        #40 reset = 1'b0;
        #100;
        chk("t1_no_partial", 32'(xfer_cnt), 0);
        chk("t1_no_err", 32'(err_cnt), 0);
        frame(32'h3C5A9, BW, 1'b0);
        chk("t1_xfer_cnt", 32'(xfer_cnt), 1);
        chk("t1_msg", 32'(last_xfer), 32'h3C5A9);

        // 2: basic frame, parity even
        do_reset();
        rx_rdy = 1'b1;
        frame(32'hA5F3C, BW, 1'b0);
        chk("t2_xfer_cnt", 32'(xfer_cnt), 1);
        chk("t2_msg", 32'(last_xfer), 32'hA5F3C);
        chk("t2_parity", 32'(last_par), 0);
        chk("t2_val_cycles", 32'(val_cycles), 1);
        chk("t2_val_low", 32'(rx_val), 0);
        chk("t2_no_err", 32'(err_cnt), 0);

        // 3: response serialised on miso
        do_reset();
        rx_rdy = 1'b1;
        tx_msg = 20'h80001;
        tx_val = 1'b1;
        frame(32'h12345, BW, 1'b0);
        chk("t3_tx_rdy_pulses", 32'(rdy_cnt), 1);
        chk("t3_miso_bits", miso_bits & 32'hFFFFF, 32'h80001);
        chk("t3_rx_msg", 32'(last_xfer), 32'h12345);
        chk("t3_miso_idle", 32'(miso), 0);

        // 4: overflow with rx_rdy low, then drain
        do_reset();
        rx_rdy = 1'b0;
        frame(32'h00001, BW, 1'b0);
        frame(32'h00003, BW, 1'b0);
        chk("t4_val", 32'(rx_val), 1);
        chk("t4_msg_held", 32'(rx_msg), 32'h00001);
        chk("t4_overflow", 32'(overflow), 1);
        chk("t4_parity", 32'(minion_parity), 1);
        rx_rdy = 1'b1;
        #50;
        chk("t4_val_drop", 32'(rx_val), 0);
        chk("t4_xfer_cnt", 32'(xfer_cnt), 1);
        chk("t4_xfer_msg", 32'(last_xfer), 32'h00001);
        chk("t4_parity_clr", 32'(minion_parity), 0);
        chk("t4_overflow_sticky", 32'(overflow), 1);

        // 5: short/long frames and a cs-only pulse
        do_reset();
        rx_rdy = 1'b1;
        frame(32'h7FFFF, 19, 1'b0);
        frame(32'h1FFFFF, 21, 1'b0);
        chk("t5_err_cnt", 32'(err_cnt), 2);
        chk("t5_no_val", 32'(val_cycles), 0);
        tx_msg = 20'h00005;
        tx_val = 1'b1;
        frame(32'h0, 0, 1'b0);
        chk("t5_zero_edge_err", 32'(err_cnt), 3);
        chk("t5_zero_edge_tx_taken", 32'(rdy_cnt), 1);
        chk("t5_no_val2", 32'(val_cycles), 0);

        // 6: rx_rdy arrives exactly in the DONE cycle of the second frame
        do_reset();
        rx_rdy = 1'b0;
        frame(32'hAAAAA, BW, 1'b0);
        frame(32'h0F0F1, BW, 1'b1);
        chk("t6_val", 32'(rx_val), 1);
        chk("t6_new_msg", 32'(rx_msg), 32'h0F0F1);
        chk("t6_overflow", 32'(overflow), 0);
        chk("t6_xfer_cnt", 32'(xfer_cnt), 1);
        chk("t6_old_msg", 32'(last_xfer), 32'hAAAAA);
        chk("t6_no_val_gap", 32'(val_falls), 0);
        chk("t6_parity", 32'(minion_parity), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
